// File: rtl/led_pkg.sv
// Shared mode encoding and counter-width helpers for the LED pattern generator.
package led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        LED_ROT_L  = 2'd0,
        LED_ROT_R  = 2'd1,
        LED_COUNT  = 2'd2,
        LED_BOUNCE = 2'd3
    } led_mode_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int step_period(input int step_ticks, input logic [MODE_W-1:0] speed);
        int p;
        p = step_ticks >> speed;
        return (p < 1) ? 1 : p;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a single-cycle tick enable once every DIV enabled cycles.
// Latency: tick decodes the count register directly, high on the cycle the count is DIV-1.
// Backpressure: none; en=0 freezes the count, clr restarts it from zero.
module tick_gen
    import led_pkg::*;
#(
    parameter int DIV = 25000
) (
    input  logic clk_25mhz,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             W    = cnt_width(DIV);
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // A clear cycle never produces a tick, so a restart always runs a full period.
    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk_25mhz) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate/count/bounce patterns stepped from a tick time base (bounce via LED_BOUNCE_EN).
// Latency: led, dir and step_pulse are registered and change together on the stepping edge.
// Backpressure: run=0 freezes all counters and the pattern; a mode change restarts the step period.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LED      = 4,
    parameter int TICK_DIV   = 25000,
    parameter int STEP_TICKS = 200
) (
    input  logic              clk_25mhz,
    input  logic              rst,
    input  logic              run,
    input  logic [1:0]        mode,
    input  logic [1:0]        speed,
    output logic [N_LED-1:0]  led,
    output logic              step_pulse,
    output logic              dir
);

    localparam int SW = cnt_width(STEP_TICKS);

    logic [MODE_W-1:0] mode_q;
    logic              mode_chg;
    logic              tick;
    logic              step_now;
    logic [SW-1:0]     step_cnt;
    logic [SW-1:0]     step_cnt_nxt;
    logic [SW-1:0]     period_m1;
    logic [N_LED-1:0]  led_nxt;
`ifdef LED_BOUNCE_EN
    logic              dir_q;
    logic              dir_nxt;
`endif

    assign mode_chg  = (mode != mode_q);
    assign period_m1 = SW'(step_period(STEP_TICKS, speed) - 1);

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_25mhz (clk_25mhz),
        .rst       (rst),
        .en        (run),
        .clr       (mode_chg),
        .tick      (tick)
    );

    always_comb begin
        // ">=" lets a speed change that shortens the period end the step on the next tick.
        step_now     = tick && (step_cnt >= period_m1);
        step_cnt_nxt = step_cnt;
        led_nxt      = led;
`ifdef LED_BOUNCE_EN
        dir_nxt      = dir_q;
`endif
        if (mode_chg) begin
            step_now     = 1'b0;
            step_cnt_nxt = '0;
            led_nxt      = N_LED'(1);
`ifdef LED_BOUNCE_EN
            dir_nxt      = 1'b0;
`endif
        end else if (tick) begin
            step_cnt_nxt = step_now ? '0 : step_cnt + SW'(1);
            if (step_now) begin
                case (led_mode_e'(mode_q))
                    LED_ROT_R: led_nxt = (led >> 1) | (led << (N_LED - 1));
                    LED_COUNT: led_nxt = led + N_LED'(1);
`ifdef LED_BOUNCE_EN
                    LED_BOUNCE: begin
                        if (N_LED > 1) begin
                            if (!dir_q) begin
                                led_nxt = led << 1;
                                if (led_nxt[N_LED-1]) dir_nxt = 1'b1;
                            end else begin
                                led_nxt = led >> 1;
                                if (led_nxt[0]) dir_nxt = 1'b0;
                            end
                        end
                    end
`endif
                    default:   led_nxt = (led << 1) | (led >> (N_LED - 1));
                endcase
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (rst) begin
            mode_q     <= mode;
            step_cnt   <= '0;
            led        <= N_LED'(1);
            step_pulse <= 1'b0;
`ifdef LED_BOUNCE_EN
            dir_q      <= 1'b0;
`endif
        end else begin
            mode_q     <= mode;
            step_cnt   <= step_cnt_nxt;
            led        <= led_nxt;
            step_pulse <= step_now;
`ifdef LED_BOUNCE_EN
            dir_q      <= dir_nxt;
`endif
        end
    end

`ifdef LED_BOUNCE_EN
    assign dir = dir_q;
`else
    assign dir = 1'b0;
`endif

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator that drives a bank of N_LED outputs from the board clock. It replaces the fixed 4-LED rotator and adds selectable patterns, run/pause control and a runtime speed select. The 1 ms time base is a single-cycle enable, not a derived clock, so the whole block runs in one clock domain. It sits directly between the board clock and the LED pins, and exports a step strobe for other logic to synchronise to.

## Interface
- N_LED, 4: number of LED outputs, range 1..32
- TICK_DIV, 25000: clock cycles per tick (1 ms at 25 MHz), minimum 1
- STEP_TICKS, 200: ticks per pattern step at speed 0, minimum 1
- clk_25mhz  in  1  source clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  1 = advance the pattern; 0 = freeze all counters and the pattern
- mode  in  2  0 rotate-left, 1 rotate-right, 2 binary count-up, 3 bounce
- speed  in  2  step period = max(1, STEP_TICKS >> speed) ticks
- led  out  N_LED  pattern register, driven directly
- step_pulse  out  1  one-cycle strobe on the cycle the pattern advances
- dir  out  1  bounce direction: 0 = toward MSB, 1 = toward LSB

## Operation
- Prescaler, width clog2(TICK_DIV):
  - counts 0..TICK_DIV-1 and then wraps to 0.
  - tick is high for the one cycle where the count equals TICK_DIV-1.
- Step counter, width clog2(STEP_TICKS):
  - advances only on cycles where tick is high.
  - when it equals period-1 on a tick, it clears and step_pulse is asserted for that cycle.
- speed is sampled on every tick.
  - If a speed change leaves the step counter at or above the new period-1, the next tick is treated as the terminal one.
- When run=0:
  - the prescaler, step counter, led and dir hold their values.
  - step_pulse is 0.
- Pattern update happens on step_pulse:
  - Mode 0: rotate left. The MSB moves into the LSB.
  - Mode 1: rotate right. The LSB moves into the MSB.
  - Mode 2: led increments by 1. All-ones wraps to 0.
  - Mode 3: one-hot walk. Shift left while dir=0 and right while dir=1.
    - dir flips on the step that lands on the MSB (dir becomes 1) or the LSB (dir becomes 0).
    - Endpoints are shown for exactly one step each: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
  - N_LED=1: led stays 1 in modes 0, 1 and 3. Mode 2 toggles between 0 and 1.
- Mode change:
  - mode is registered internally as mode_q.
  - On any cycle where mode differs from mode_q:
    - led loads 1 (LSB only).
    - dir clears.
    - the step counter and prescaler clear.
    - no step_pulse is issued that cycle.
  - A mode change restarts the full step period. It takes precedence over a coincident step, and it applies even when run=0.
- Reset values: led=1 (LSB only), dir=0, step_pulse=0, prescaler=0, step counter=0, mode_q=mode.

## Timing
- Every output is registered.
- led, dir and step_pulse all change on the same clock edge.
- After reset release with run=1 held, the first step_pulse comes in cycle TICK_DIV*period after the first non-reset cycle.
  - For default parameters at speed 0 this is 5,000,000 cycles, i.e. 200 ms.
- Steady-state step interval is exactly TICK_DIV*period cycles, with no drift.
- Pausing with run=0 and resuming preserves the partial count exactly. The remaining cycles to the next step are unchanged.
- Reset asserted mid-step aborts the step. The outputs show their reset values on the cycle after the reset edge.

## Configuration
- LED_BOUNCE_EN:
  - Defined: mode 3 is bounce, as described above, and dir is driven as described.
  - Undefined: mode 3 behaves identically to mode 0, dir is tied to 0, and the bounce logic is removed.

## Structure
- Package led_pkg:
  - mode enum: LED_ROT_L, LED_ROT_R, LED_COUNT, LED_BOUNCE.
  - localparam width helpers.
- Sub-module tick_gen, parameter DIV:
  - the prescaler, outputting the tick enable.
  - reusable for other ms-based blocks.
- The step counter, mode-change detect and pattern logic stay in led_pattern_gen.

## Test plan
All scenarios use the bench parameters N_LED=4, TICK_DIV=4, STEP_TICKS=3.

- Reset, then run=1, mode=0, speed=0 -> step_pulse at cycle 12, then every 12 cycles; led sequence 0001, 0010, 0100, 1000, 0001.
- Mode 1, then mode 2, each from reset -> mode 1: led 0001, 1000, 0100, 0010; mode 2: led 0001, 0010, 0011, ... 1111, 0000 (wrap).
- Mode 3 with LED_BOUNCE_EN defined -> led 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; dir goes to 1 on the step that reaches 1000 and back to 0 on the step that reaches 0001. Same stimulus with the macro undefined -> rotate-left sequence and dir constantly 0.
- run dropped to 0 for 50 cycles at cycle 7 -> no step_pulse while paused; the first step comes 5 cycles after run returns to 1.
- Mode change from 0 to 2 on the same cycle a step is due -> led=0001, step_pulse=0, next step 12 cycles later. speed=1 (period 1 tick) -> a step every 4 cycles.
- rst pulsed for 1 cycle mid-period while led=0100 -> led=0001 and step_pulse=0 on the next cycle; next step 12 cycles after reset drops.
